fht_reorder: RTL and testbench

Hardware reorder engine for the FHT/IFHT chain. It replaces the bench-side bit-reverse copy that runs between the forward and inverse transforms. It reads all `N_BANK` result banks of one FHT RAM in bit-reversed or linear row order and writes them to the loader ports of the next transform in natural row order. All banks are handled in parallel. An optional 1/N normalisation stage is available for the IFHT result.

---
 rtl/fht_reorder_pkg.sv | 37 +++
 rtl/fht_delay_line.sv | 32 +++
 rtl/fht_reorder.sv | 165 ++++++++++++++++
 tb/tb_fht_reorder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_reorder_pkg.sv
// Shared types and helpers for the FHT/IFHT reorder engine.
// Optional 1/N normalisation is enabled by defining FHT_REORDER_NORM_EN.
package fht_reorder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_e;

    localparam int unsigned REV_MAX = 32;
    localparam int unsigned REV_IW  = 5;

    // Reverses the low w bits of x; bits at and above w come back as zero.
    function automatic logic [REV_MAX-1:0] f_bit_rev(
        input logic [REV_MAX-1:0] x,
        input int unsigned        w
    );
        logic [REV_MAX-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < REV_MAX; i++) begin
            if (i < w) begin
                r[REV_IW'(i)] = x[REV_IW'(w - 1 - i)];
            end
        end
        return r;
    endfunction

    function automatic int unsigned f_lane_lo(
        input int unsigned k,
        input int unsigned w
    );
        return k * w;
    endfunction

endpackage

// File: rtl/fht_delay_line.sv
// Synchronously cleared shift register.
// Carries the issue-valid flag and row counter across the source RAM read latency.
module fht_delay_line
    import fht_reorder_pkg::*;
#(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fht_reorder.sv
// Reorder engine: reads N_BANK source banks linearly or bit-reversed, writes natural order.
// FHT_REORDER_NORM_EN adds a rounding >>> NORM_SHIFT on every lane in the write stage.
module fht_reorder
    import fht_reorder_pkg::*;
#(
    parameter int unsigned D_BIT      = 18,
    parameter int unsigned A_BIT      = 8,
    parameter int unsigned N_BANK     = 4,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned NORM_SHIFT = 10
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iSTART,
    input  logic                    iMODE,
    output logic [A_BIT-1:0]        oADDR_RD,
    input  logic [N_BANK*D_BIT-1:0] iDATA,
    output logic [A_BIT-1:0]        oADDR_WR,
    output logic [N_BANK*D_BIT-1:0] oDATA,
    output logic [N_BANK-1:0]       oWE,
    output logic                    oBUSY,
    output logic                    oRDY
);

`ifdef FHT_REORDER_NORM_EN
    localparam bit NORM_EN = 1'b1;
`else
    localparam bit NORM_EN = 1'b0;
`endif
    localparam int unsigned SHIFT = NORM_EN ? NORM_SHIFT : 0;
    localparam int unsigned DL_W  = A_BIT + 1;

    state_e           state_q, state_d;
    logic [A_BIT-1:0] cnt_q, cnt_d;
    logic [A_BIT-1:0] last_q, last_d;
    logic [2:0]       drain_q, drain_d;
    logic             mode_q, mode_d;
    logic             issue;
    logic [A_BIT-1:0] rd_addr;
    logic [DL_W-1:0]  dl_in, dl_out;
    logic             wr_vld;
    logic [A_BIT-1:0] wr_cnt;
    logic             we_q;
    logic [A_BIT-1:0] waddr_q;

    assign rd_addr = mode_q
        ? A_BIT'(f_bit_rev(REV_MAX'(cnt_q), A_BIT))
        : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        drain_d = drain_q;
        mode_d  = mode_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (iSTART) begin
                    mode_d  = iMODE;
                    cnt_d   = '0;
                    drain_d = '0;
                    state_d = READ;
                end
            end
            READ: begin
                issue  = 1'b1;
                last_d = rd_addr;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last row needs RD_LAT cycles of read plus one write cycle.
                if (drain_q == 3'(RD_LAT)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            drain_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            drain_q <= drain_d;
            mode_q  <= mode_d;
        end
    end

    assign oADDR_RD = (state_q == READ) ? rd_addr : last_q;
    assign oBUSY    = (state_q == READ) || (state_q == DRAIN);
    assign oRDY     = (state_q == DONE);

    assign dl_in = {issue, cnt_q};

    fht_delay_line #(
        .DEPTH (RD_LAT),
        .WIDTH (DL_W)
    ) u_dly (
        .clk_i (iCLK),
        .rst_i (iRESET),
        .d_i   (dl_in),
        .q_o   (dl_out)
    );

    assign {wr_vld, wr_cnt} = dl_out;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            we_q <= wr_vld;
            if (wr_vld) begin
                waddr_q <= wr_cnt;
            end
        end
    end

    assign oWE      = {N_BANK{we_q}};
    assign oADDR_WR = waddr_q;

    for (genvar k = 0; k < N_BANK; k++) begin : g_lane
        logic [D_BIT-1:0] x;
        logic [D_BIT-1:0] y;
        logic [D_BIT-1:0] data_q;

        assign x = iDATA[f_lane_lo(k, D_BIT) +: D_BIT];

        if (SHIFT == 0) begin : g_pass
            assign y = x;
        end else begin : g_norm
            // One guard bit keeps the rounding add from overflowing.
            localparam logic signed [D_BIT:0] RND =
                (D_BIT+1)'(1) << (SHIFT - 1);
            logic signed [D_BIT:0] sum;
            assign sum = $signed({x[D_BIT-1], x}) + RND;
            assign y   = D_BIT'(sum >>> SHIFT);
        end

        always_ff @(posedge iCLK) begin
            if (iRESET) begin
                data_q <= '0;
            end else if (wr_vld) begin
                data_q <= y;
            end
        end

        assign oDATA[f_lane_lo(k, D_BIT) +: D_BIT] = data_q;
    end

endmodule

// File: tb/tb_fht_reorder.sv
// Bench for fht_reorder: two instances (read latency 1 and 2), RAM models,
// table of runs checked cycle by cycle against a timing/data reference model.
module tb_fht_reorder;

    localparam int DB = 18;
    localparam int AB = 3;
    localparam int NB = 4;
    localparam int S  = 8;
    localparam int NS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [2];
    logic          start [2];
    logic          mode  [2];
    wire  [NB*DB-1:0] din  [2];
    logic [AB-1:0]    ard  [2];
    logic [AB-1:0]    awr  [2];
    logic [NB*DB-1:0] dout [2];
    logic [NB-1:0]    we   [2];
    logic             busy [2];
    logic             rdy  [2];

    fht_reorder #(
        .D_BIT(DB), .A_BIT(AB), .N_BANK(NB), .RD_LAT(1), .NORM_SHIFT(NS)
    ) dut0 (
        .iCLK(clk), .iRESET(rst[0]), .iSTART(start[0]), .iMODE(mode[0]),
        .oADDR_RD(ard[0]), .iDATA(din[0]), .oADDR_WR(awr[0]),
        .oDATA(dout[0]), .oWE(we[0]), .oBUSY(busy[0]), .oRDY(rdy[0])
    );

    fht_reorder #(
        .D_BIT(DB), .A_BIT(AB), .N_BANK(NB), .RD_LAT(2), .NORM_SHIFT(NS)
    ) dut1 (
        .iCLK(clk), .iRESET(rst[1]), .iSTART(start[1]), .iMODE(mode[1]),
        .oADDR_RD(ard[1]), .iDATA(din[1]), .oADDR_WR(awr[1]),
        .oDATA(dout[1]), .oWE(we[1]), .oBUSY(busy[1]), .oRDY(rdy[1])
    );

    logic [DB-1:0] src [NB][S];
    logic [DB-1:0] dst [NB][S];

    function automatic logic [NB*DB-1:0] row_word(input logic [AB-1:0] a);
        logic [NB*DB-1:0] w;
        for (int k = 0; k < NB; k++) w[k*DB +: DB] = src[k][a];
        return w;
    endfunction

    // Source RAMs with 1 and 2 cycles of read latency.
    logic [NB*DB-1:0] p0, p1a, p1b;
    always @(posedge clk) begin
        p0  <= row_word(ard[0]);
        p1a <= row_word(ard[1]);
        p1b <= p1a;
    end
    assign din[0] = p0;
    assign din[1] = p1b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h, required 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 1 : 2;
    endfunction

    function automatic int brev(input int x);
        int r = 0;
        for (int i = 0; i < AB; i++) r = r * 2 + ((x >> i) & 1);
        return r;
    endfunction

    function automatic int fmap(input int r, input bit m);
        return m ? brev(r) : r;
    endfunction

    function automatic logic [DB-1:0] to18(input int v);
        return v[DB-1:0];
    endfunction

    function automatic logic [DB-1:0] nrm(input logic [DB-1:0] v);
        int s;
        s = int'($signed(v));
`ifdef FHT_REORDER_NORM_EN
        s = (s + (1 << (NS - 1))) >>> NS;
`endif
        return to18(s);
    endfunction

    task automatic run(input int sel, input bit m, input int extra, input int rc,
                       output int nw, output int nr, output int f_rdy, output int l_rdy);
        int L = lat_of(sel);
        int acc[$];
        int ncyc;
        acc.push_back(0);
        nw = 0; nr = 0; f_rdy = -1; l_rdy = -1;
        for (int k = 0; k < NB; k++)
            for (int r = 0; r < S; r++) dst[k][r] = '0;
        ncyc = (extra > 0) ? extra + S + L + 4 : S + L + 4;
        mode[sel]  = m;
        start[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[sel] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            bit e_busy, e_rdy, e_we, abrt;
            int e_rd, e_wr, rel;
            cyc = c;
            e_busy = 0; e_rdy = 0; e_we = 0; e_rd = -1; e_wr = -1;
            abrt = (rc > 0) && (c > rc);
            foreach (acc[i]) begin
                rel = c - acc[i];
                if (rel >= 1 && rel <= S + 1 + L) e_busy = 1;
                if (rel == S + 2 + L) e_rdy = 1;
                if (rel >= 1 && rel <= S) e_rd = fmap(rel - 1, m);
                else if (rel > S && rel <= S + 1 + L) e_rd = fmap(S - 1, m);
                if (rel >= 2 + L && rel <= S + 1 + L) begin
                    e_we = 1;
                    e_wr = rel - 2 - L;
                end
            end
            if (abrt) begin
                e_busy = 0; e_rdy = 0; e_we = 0; e_rd = 0; e_wr = 0;
            end
            chk("busy", busy[sel], e_busy);
            chk("rdy", rdy[sel], e_rdy);
            chk("we", we[sel], e_we ? 4'hF : 4'h0);
            if (e_rd >= 0) chk("addr_rd", ard[sel], e_rd);
            if (e_we) begin
                chk("addr_wr", awr[sel], e_wr);
                for (int k = 0; k < NB; k++)
                    chk("data", dout[sel][k*DB +: DB], nrm(src[k][fmap(e_wr, m)]));
            end else if (abrt) begin
                chk("addr_wr_rst", awr[sel], 0);
                chk("data_rst", dout[sel], 0);
            end
            if (we[sel][0]) begin
                nw++;
                for (int k = 0; k < NB; k++) dst[k][awr[sel]] = dout[sel][k*DB +: DB];
            end
            if (rdy[sel]) begin
                nr++;
                if (f_rdy < 0) f_rdy = c;
                l_rdy = c;
            end
            if (c == extra && !e_busy && !abrt) acc.push_back(c);
            start[sel] = (c == extra);
            rst[sel]   = (c == rc);
            @(negedge clk);
        end
        start[sel] = 1'b0;
        rst[sel]   = 1'b0;
    endtask

    typedef struct {
        string nm;
        int    sel;
        bit    m;
        int    pat;
        int    extra;
        int    rc;
        int    x_nw;
        int    x_nr;
        int    x_first;
        int    x_last;
    } tcase_t;

    typedef struct {
        int x;
        int y;
    } nvec_t;

    initial begin
        tcase_t tc[$];
        nvec_t  nv[$];
        int     b0[8];
        int     nw, nr, fr, lr;

        tc.push_back('{"bitrev",      0, 1'b1, 0,  0, 0,  8, 1, 11, 11});
        tc.push_back('{"linear",      0, 1'b0, 0,  0, 0,  8, 1, 11, 11});
        tc.push_back('{"busy_start",  0, 1'b1, 1,  4, 0,  8, 1, 11, 11});
        tc.push_back('{"reset_mid",   0, 1'b0, 1,  0, 5,  3, 0, -1, -1});
        tc.push_back('{"after_reset", 0, 1'b1, 1,  0, 0,  8, 1, 11, 11});
        tc.push_back('{"b2b",         1, 1'b1, 1, 12, 0, 16, 2, 12, 24});
        tc.push_back('{"lat2_linear", 1, 1'b0, 1,  0, 0,  8, 1, 12, 12});

        nv.push_back('{7, 2});
        nv.push_back('{6, 2});
        nv.push_back('{-6, -1});
        nv.push_back('{-7, -2});
        nv.push_back('{131071, 32768});
        nv.push_back('{-131072, -32768});

        b0 = '{0, 4, 2, 6, 1, 5, 3, 7};

        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; start[s] = 1'b0; mode[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", busy[s], 0);
            chk("rst_rdy", rdy[s], 0);
            chk("rst_we", we[s], 0);
            chk("rst_addr_rd", ard[s], 0);
            chk("rst_addr_wr", awr[s], 0);
            chk("rst_data", dout[s], 0);
            rst[s] = 1'b0;
        end
        @(negedge clk);

        foreach (tc[i]) begin
            for (int k = 0; k < NB; k++)
                for (int r = 0; r < S; r++)
                    src[k][r] = (tc[i].pat == 0) ? to18(16 * k + r) : to18(int'($urandom));
            run(tc[i].sel, tc[i].m, tc[i].extra, tc[i].rc, nw, nr, fr, lr);
            cyc = 0;
            chk({tc[i].nm, ".writes"}, nw, tc[i].x_nw);
            chk({tc[i].nm, ".rdys"}, nr, tc[i].x_nr);
            chk({tc[i].nm, ".first_rdy"}, fr, tc[i].x_first);
            chk({tc[i].nm, ".last_rdy"}, lr, tc[i].x_last);
            if (i == 0) begin
                for (int r = 0; r < S; r++) chk("bitrev.bank0", dst[0][r], nrm(to18(b0[r])));
                chk("bitrev.bank2_row1", dst[2][1], nrm(to18(36)));
            end
            if (i == 1) begin
                for (int k = 0; k < NB; k++)
                    for (int r = 0; r < S; r++) chk("linear.copy", dst[k][r], nrm(src[k][r]));
            end
        end

        for (int r = 0; r < S; r++)
            for (int k = 0; k < NB; k++)
                src[k][r] = (r < nv.size()) ? to18(nv[r].x) : '0;
        run(0, 1'b0, 0, 0, nw, nr, fr, lr);
        cyc = 0;
        foreach (nv[i]) begin
            for (int k = 0; k < NB; k++) begin
`ifdef FHT_REORDER_NORM_EN
                chk("norm", dst[k][i], to18(nv[i].y));
`else
                chk("norm_pass", dst[k][i], to18(nv[i].x));
`endif
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
